mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//               Shift-add multiply and restoring divide, one bit per cycle.
//               Results are committed to HI/LO one cycle after the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] c_last_iter = 6'd31;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_is_div;
  logic              r_sign_q;     // product sign for multiply, quotient sign for divide
  logic              r_sign_r;     // remainder sign (dividend sign)
  logic [XLEN-1:0]   r_b;          // magnitude of operand2
  logic [2*XLEN-1:0] r_acc;        // {upper, lower}: product or {remainder, quotient}
  logic [5:0]        r_cnt;

  logic              w_signed;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_accept;
  logic              w_dz;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN:0]   w_div_shift;
  logic [XLEN:0]     w_div_trial;
  logic              w_div_ok;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  // Operand capture: signed ops work on magnitudes, sign is restored in FIN
  assign w_signed = ~op[0];
  assign w_mag1   = (w_signed && operand1[XLEN-1]) ? (~operand1 + 1'b1) : operand1;
  assign w_mag2   = (w_signed && operand2[XLEN-1]) ? (~operand2 + 1'b1) : operand2;
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_dz     = op[1] && (operand2 == '0);

  // Multiply step: conditionally add multiplicand to upper half, shift right
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: shift {rem, dividend} left, subtract divisor if it fits
  assign w_div_shift = {r_acc, 1'b0};
  assign w_div_trial = w_div_shift[2*XLEN:XLEN] - {1'b0, r_b};
  assign w_div_ok    = ~w_div_trial[XLEN];
  assign w_div_next  = {(w_div_ok ? w_div_trial[XLEN-1:0] : w_div_shift[2*XLEN-1:XLEN]),
                        w_div_shift[XLEN-1:1], w_div_ok};

  // Sign correction applied when the result is committed
  assign w_prod = r_sign_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_sign_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_sign_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  // Control FSM, datapath iteration and HI/LO register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      // MTHI/MTLO; a result commit in FIN is ordered after and wins
      if (!r_busy) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_is_div   <= op[1];
            r_sign_q   <= w_signed & (operand1[XLEN-1] ^ operand2[XLEN-1]);
            r_sign_r   <= w_signed & op[1] & operand1[XLEN-1];
            r_b        <= w_mag2;
            r_acc      <= {{XLEN{1'b0}}, w_mag1};
            r_cnt      <= '0;
            r_div_zero <= w_dz;
            if (w_dz) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_last_iter) r_state <= S_FIN;
        end
        S_FIN: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*XLEN-1:XLEN];
            r_lo <= w_prod[XLEN-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .operand1 (operand1),
    .operand2 (operand2),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start at the current negedge; operands are scrambled after capture
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    op       = o;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = 32'hDEADBEEF;
    operand2 = 32'h0BADF00D;
    op       = ~o;
  endtask

  // Wait (bounded) for done, counting busy cycles and elapsed cycles
  task automatic wait_done(output int bc, output int waits, output logic got);
    bc    = 0;
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      waits++;
      if (busy) bc++;
      if (done) got = 1'b1;
    end
  endtask

  // MTHI/MTLO write at the next edge, returns at the following negedge
  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    hi_we = hw;
    lo_we = lw;
    wdata = d;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int   bc;
    int   waits;
    logic got;
    start_op(o, a, b);
    wait_done(bc, waits, got);
    chk({tag, "_done"}, {31'd0, got}, 32'd1);
    chk({tag, "_busy_cycles"}, bc, 32'd33);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    int   bc;
    int   waits;
    logic got;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand1 = '0; operand2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-operation: MULT 7*9 aborted during CALC
    start_op(2'b00, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    chk("midop_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_hi", hi, 32'd0);
    chk("midop_rst_lo", lo, 32'd0);
    chk("midop_rst_busy", {31'd0, busy}, 32'd0);
    chk("midop_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midop_after_busy", {31'd0, busy}, 32'd0);
    chk("midop_after_done", {31'd0, done}, 32'd0);
    chk("midop_after_hi", hi, 32'd0);
    chk("midop_after_lo", lo, 32'd0);

    // Multiplies
    run_check("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);
    chk("multu_done_pulse", {31'd0, done}, 32'd0);
    chk("multu_idle_busy", {31'd0, busy}, 32'd0);
    run_check("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);

    // Divides
    run_check("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_check("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    @(negedge clk);

    // Divide by zero keeps preloaded HI/LO
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    start_op(2'b11, 32'd5, 32'd0);
    wait_done(bc, waits, got);
    chk("dz_done", {31'd0, got}, 32'd1);
    chk("dz_latency", waits, 32'd1);
    chk("dz_busy_cycles", bc, 32'd0);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // Back-to-back: start held in the done cycle
    start_op(2'b01, 32'd3, 32'd4);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    chk("b2b_dz_cleared", {31'd0, div_zero}, 32'd0);
    repeat (3) @(negedge clk);
    // Ignored start and MTLO while busy
    start = 1'b1; op = 2'b01; operand1 = 32'd5; operand2 = 32'd5;
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; lo_we = 1'b0;
    chk("busy_mtlo_ignored", lo, 32'h22);
    wait_done(bc, waits, got);
    chk("b2b_done", {31'd0, got}, 32'd1);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd12);
    @(negedge clk);
    chk("b2b_no_restart_busy", {31'd0, busy}, 32'd0);
    chk("b2b_no_restart_done", {31'd0, done}, 32'd0);

    // MTLO while idle, then MTLO on the same edge as start
    mt(1'b0, 1'b1, 32'hABCD);
    chk("idle_mtlo_lo", lo, 32'hABCD);
    chk("idle_mtlo_hi", hi, 32'd0);
    mt(1'b0, 1'b1, 32'h5555);
    lo_we = 1'b1; wdata = 32'hABCD;
    start_op(2'b01, 32'd2, 32'd3);
    lo_we = 1'b0;
    chk("mtlo_start_lo", lo, 32'hABCD);
    chk("mtlo_start_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("mtlo_mid_lo", lo, 32'hABCD);
    wait_done(bc, waits, got);
    chk("mtlo_op_done", {31'd0, got}, 32'd1);
    chk("mtlo_op_lo", lo, 32'd6);
    chk("mtlo_op_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
